// File: rtl/mc8051_mc_dec_pipe.sv
// mc8051_mc_dec_pipe: registered microcode field decoder with handshake, stall/flush, repeat sequencing and illegal-word detection
module mc8051_mc_dec_pipe #(
  parameter int MCODE_WIDTH = 72,
  parameter int STEP_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [MCODE_WIDTH-1:0]  i_mc_b,
  input  logic                    i_mc_valid,
  output logic                    o_mc_ready,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_dec_valid,
  output logic [STEP_W-1:0]       o_step,
  output logic                    o_last_step,
  output logic                    o_mc_err,
  output logic [2:0]              o_s2_fetch_mode_sel,
  output logic                    o_is_s2_update_pc,
  output logic [3:0]              o_s2_mem_addr_sel,
  output logic [2:0]              o_s3_fetch_mode_sel,
  output logic                    o_is_s3_update_pc,
  output logic [2:0]              o_s3_mem_addr_sel,
  output logic [2:0]              o_s5_write_mode_sel,
  output logic [3:0]              o_mem_wdata_sel,
  output logic [3:0]              o_s5_mem_addr_sel,
  output logic [2:0]              o_alu_in1_sel,
  output logic [2:0]              o_alu_in0_sel,
  output logic [4:0]              o_alu_mode,
  output logic [2:0]              o_op_psw_mode,
  output logic [2:0]              o_pc_reload_mode_sel,
  output logic [3:0]              o_jp_judg_mode,
  output logic [2:0]              o_reg_sor_sel,
  output logic [2:0]              o_reg_tar_sel,
  output logic [MCODE_WIDTH-65:0] o_mc_ext
);
  typedef enum logic [1:0] {IDLE, ISSUE, LAST} state_t;
  state_t state, state_nx;
  logic [STEP_W-1:0] step, rcnt, r_in, step_inc;
  logic [52:0] fld;
  logic [MCODE_WIDTH-65:0] ext;
  logic [62:0] hi_bits;
  logic err, accept, illegal;
  assign r_in = i_mc_b[63] ? i_mc_b[52+STEP_W:53] : '0;
  assign hi_bits = i_mc_b[62:0] >> (53 + STEP_W);
  assign illegal = (i_mc_b[63] & ~|i_mc_b[52+STEP_W:53]) | (|hi_bits);
  assign step_inc = step + STEP_W'(1);
  assign o_mc_ready = ~i_flush & ~i_stall & (state != ISSUE);
  assign accept = i_mc_valid & o_mc_ready;
  always_comb begin
    state_nx = i_flush ? IDLE :
               i_stall ? state :
               accept ? ((r_in == '0) ? LAST : ISSUE) :
               (state == ISSUE) ? ((step_inc == rcnt) ? LAST : ISSUE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      step  <= '0;
      rcnt  <= '0;
      fld   <= '0;
      ext   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (i_flush) begin
        step <= '0;
        rcnt <= '0;
        fld  <= '0;
        ext  <= '0;
        err  <= 1'b0;
      end else if (i_stall) begin
        err <= 1'b0;
      end else begin
        err <= accept & illegal;
        if (accept) begin
          step <= '0;
          rcnt <= r_in;
          fld  <= i_mc_b[52:0];
          ext  <= i_mc_b[MCODE_WIDTH-1:64];
        end else if (state == ISSUE) begin
          step <= step_inc;
        end
      end
    end
  end
  assign o_dec_valid          = state != IDLE;
  assign o_last_step          = state == LAST;
  assign o_step               = step;
  assign o_mc_err             = err;
  assign o_is_s2_update_pc    = fld[0];
  assign o_s2_fetch_mode_sel  = fld[3:1];
  assign o_s2_mem_addr_sel    = fld[7:4];
  assign o_is_s3_update_pc    = fld[8];
  assign o_s3_fetch_mode_sel  = fld[11:9];
  assign o_s3_mem_addr_sel    = fld[14:12];
  assign o_mem_wdata_sel      = fld[18:15];
  assign o_s5_write_mode_sel  = fld[21:19];
  assign o_s5_mem_addr_sel    = fld[25:22];
  assign o_alu_mode           = fld[30:26];
  assign o_alu_in0_sel        = fld[33:31];
  assign o_alu_in1_sel        = fld[36:34];
  assign o_op_psw_mode        = fld[39:37];
  assign o_jp_judg_mode       = fld[43:40];
  assign o_pc_reload_mode_sel = fld[46:44];
  assign o_reg_tar_sel        = fld[49:47];
  assign o_reg_sor_sel        = fld[52:50];
  assign o_mc_ext             = ext;
endmodule

// File: doc/mc8051_mc_dec_pipe.md
Name: mc8051_mc_dec_pipe
Overview:
Parametrised successor to the microcode field decoder. Takes microcode words from the microcode ROM through a valid/ready handshake and registers them into per-stage control fields. Adds stall/flush control, multi-cycle repeat sequencing with a step counter, and detection of reserved or illegal encodings. Sits between the microcode ROM and the S2/S3/S5 datapath control of the mc8051 core.
Parameters:
MCODE_WIDTH, 72, microcode word width (>=65); bits [MCODE_WIDTH-1:64] are the extension field.
STEP_W, 3, width of the repeat-count field at [52+STEP_W:53]; 53+STEP_W must be <=63.
Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
i_mc_b  in  MCODE_WIDTH  microcode word
i_mc_valid  in  1  i_mc_b valid
o_mc_ready  out  1  decoder accepts i_mc_b this cycle
i_stall  in  1  downstream hold; all state frozen
i_flush  in  1  discard the held word and any remaining repeats
o_dec_valid  out  1  decoded fields valid
o_step  out  STEP_W  current repeat index, 0-based
o_last_step  out  1  final cycle of the current word
o_mc_err  out  1  one-cycle pulse: the accepted word is illegal
o_s2_fetch_mode_sel/o_is_s2_update_pc  out  3/1  from [3:1]/[0]
o_s2_mem_addr_sel  out  4  [7:4]
o_s3_fetch_mode_sel/o_is_s3_update_pc  out  3/1  from [11:9]/[8]
o_s3_mem_addr_sel  out  3  [14:12]
o_s5_write_mode_sel/o_mem_wdata_sel  out  3/4  from [21:19]/[18:15]
o_s5_mem_addr_sel  out  4  [25:22]
o_alu_in1_sel/o_alu_in0_sel/o_alu_mode  out  3/3/5  from [36:34]/[33:31]/[30:26]
o_op_psw_mode  out  3  [39:37]
o_pc_reload_mode_sel/o_jp_judg_mode  out  3/4  from [46:44]/[43:40]
o_reg_sor_sel/o_reg_tar_sel  out  3/3  from [52:50]/[49:47]
o_mc_ext  out  MCODE_WIDTH-64  extension field, registered
Behaviour:
- Reset: every output 0, including o_dec_valid, o_step, o_mc_err and all fields. o_mc_ready goes to 1 after reset release.
- Ready is combinational: o_mc_ready = ~i_flush & ~i_stall & (~o_dec_valid | o_last_step).
- Accept condition: i_mc_valid & o_mc_ready.
- On accept, next cycle: all fields and o_mc_ext load from i_mc_b; o_dec_valid=1; o_step=0; the repeat count R is latched internally.
- Latency: 1 cycle from accept to fields visible.
- Repeat count: R = i_mc_b[52+STEP_W:53] if bit[63]=1, otherwise R=0. The word is presented for R+1 cycles, excluding stall cycles.
- o_last_step = o_dec_valid & (o_step==R).
- Unstalled cycle with o_dec_valid & ~o_last_step: o_step increments and fields hold.
- Unstalled cycle with o_last_step: if an accept occurs, back-to-back load with no bubble; otherwise o_dec_valid=0 and fields hold their last values.
- States: IDLE (~o_dec_valid), ISSUE (valid, step<R), LAST (valid, step==R). Transitions follow the rules above.
- Stall (i_stall=1, i_flush=0): all registers hold, o_mc_err drops to 0, no accept.
- Flush has the highest priority, including over stall and a pending input. Next cycle: o_dec_valid=0, o_step=0, all fields cleared to 0, no accept. An in-flight multi-cycle word is abandoned mid-repeat.
- Illegal word, checked on accept: bit[63]=1 with count field 0, OR any of bits [62:53+STEP_W] nonzero. o_mc_err=1 for exactly the cycle the word first appears; the word is still issued normally.
- No other field values are checked.
- Reset asserted mid-repeat: immediate return to the reset values; no partial word survives.
Test Plan:
- Reset, then i_mc_b=0x00_0000_0000_0012_3456 valid for 1 cycle -> next cycle o_dec_valid=1, o_s2_mem_addr_sel=5, o_is_s2_update_pc=0, o_s2_fetch_mode_sel=3, o_step=0, o_last_step=1; the cycle after, o_dec_valid=0.
- Multi-cycle word: bit63=1, count=3, i_mc_valid held high with a second word behind it -> o_step 0,1,2,3, o_mc_ready=1 only in step 3; second word appears the cycle after step 3 with no bubble.
- i_stall asserted during step 1 of a count=2 word for 4 cycles -> o_step stays 1 and o_mc_ready=0 throughout; after release, steps 2 then idle.
- i_flush during step 1 of a count=5 word, with i_stall=1 and i_mc_valid=1 in the same cycle -> next cycle o_dec_valid=0, all fields 0, input not accepted; input accepted the following cycle.
- Illegal words: bit63=1 with count 0 -> o_mc_err high 1 cycle, single-cycle issue; bit[60]=1 -> o_mc_err high 1 cycle, fields still decoded.
- Extension field: MCODE_WIDTH=72 with i_mc_b[71:64]=0xA5 -> o_mc_ext=0xA5; o_is_s3_update_pc follows bit 8 independently of bit 0.
